// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - byte-stream loader packing MSB-first words into the instruction memory write port
module mem_loader #(
    parameter int mem_width  = 16,
    parameter int mem_length = 16,
    parameter int add_length = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [add_length:0]   word_count,
    input  logic                  abort,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [add_length-1:0] wr_address,
    output logic [mem_width-1:0]  wr_data,
    output logic                  wr_en,
    output logic                  ce,
    output logic                  busy,
    output logic                  done,
    output logic [add_length:0]   words_written
);

    localparam int BYTES = mem_width / 8;
    localparam int BW    = $clog2(BYTES + 1);
    localparam int CW    = add_length + 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES - 1);
    localparam logic [CW-1:0] MAX_COUNT = CW'(mem_length);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t                 state;
    logic [CW-1:0]          count;
    logic [BW-1:0]          byte_cnt;
    logic [mem_width+7:0]   shifted;
    logic [CW-1:0]          clamped;
    logic [CW-1:0]          next_written;

    always_comb begin
        shifted      = {wr_data, in_data};
        clamped      = (word_count > MAX_COUNT) ? MAX_COUNT : word_count;
        next_written = words_written + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            byte_cnt      <= '0;
            in_ready      <= 1'b0;
            wr_en         <= 1'b0;
            ce            <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            wr_address    <= '0;
            wr_data       <= '0;
            words_written <= '0;
        end else begin
            done  <= 1'b0;
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        count         <= clamped;
                        words_written <= '0;
                        wr_address    <= '0;
                        byte_cnt      <= '0;
                        busy          <= 1'b1;
                        ce            <= 1'b1;
                        if (clamped == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= COLLECT;
                            in_ready <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (abort) begin
                        state    <= IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        ce       <= 1'b0;
                        byte_cnt <= '0;
                    end else if (in_valid && in_ready) begin
                        wr_data <= shifted[mem_width-1:0];
                        if (byte_cnt == LAST_BYTE) begin
                            // Word complete: stop accepting bytes while the write strobe is out
                            byte_cnt <= '0;
                            in_ready <= 1'b0;
                            wr_en    <= 1'b1;
                            state    <= WRITE;
                        end else begin
                            byte_cnt <= byte_cnt + BW'(1);
                        end
                    end
                end
                WRITE: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        ce    <= 1'b0;
                    end else begin
                        words_written <= next_written;
                        if (next_written == count) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            wr_address <= wr_address + add_length'(1);
                            in_ready   <= 1'b1;
                            state      <= COLLECT;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    ce    <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
